// File: rtl/srec_dumper.sv
// srec_dumper: reads a block of memory through the mem_controller port and streams it as
// Motorola S3 data records plus one S7 terminator. Define SREC_DUMP_S0_EN to prefix an S0 header.
module srec_dumper #(
  parameter int unsigned BYTES_PER_REC = 16,
  parameter int unsigned MEM_LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_address,
  input  logic [31:0] byte_count,
  input  logic [31:0] entry_address,
  output logic [31:0] mem_address,
  output logic        mem_wren,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 32;
  localparam int unsigned NW = 6;   // record byte counters, up to 32
  localparam int unsigned IW = 4;   // character index within a state
  localparam int unsigned LW = 8;   // memory latency counter

  localparam logic [7:0]  CH_S   = 8'h53;
  localparam logic [7:0]  CH_0   = 8'h30;
  localparam logic [7:0]  CH_3   = 8'h33;
  localparam logic [7:0]  CH_5   = 8'h35;
  localparam logic [7:0]  CH_7   = 8'h37;
  localparam logic [7:0]  CH_LF  = 8'h0A;
  localparam logic [87:0] S0_REC = "S0030000FC\n";

  typedef enum logic [3:0] {
    IDLE, HDR, CNT, ADDR, RD, DATA, CSUM, EOL, TERM, DONE, S0
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, last_idx;
  logic [LW-1:0]   lat_q, lat_d;
  logic [AW-1:0]   rec_addr_q, rec_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   remaining_q, remaining_d;
  logic [AW-1:0]   entry_q, entry_d;
  logic [AW-1:0]   word_q, word_d;
  logic [2:0]      word_bytes_q, word_bytes_d;
  logic [NW-1:0]   rec_n_q, rec_n_d;
  logic [NW-1:0]   rec_left_q, rec_left_d;
  logic [7:0]      csum_q, csum_d;
  logic [AW-1:0]   mem_address_d;
  logic [7:0]      out_char_d;
  logic            out_valid_d, busy_d, done_d;
  logic [7:0]      cnt_byte, term_sum;
  logic [2:0]      wb;
  logic            adv, load;

  function automatic logic [7:0] hex_c(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
  endfunction

  function automatic logic [3:0] nib32(input logic [31:0] v, input logic [2:0] i);
    return 4'(v >> (5'd28 - {i, 2'b00}));
  endfunction

  function automatic logic [3:0] nib8(input logic [7:0] v, input logic lo);
    return lo ? v[3:0] : v[7:4];
  endfunction

  function automatic logic [7:0] byte_sum(input logic [31:0] v);
    return v[31:24] + v[23:16] + v[15:8] + v[7:0];
  endfunction

  // Leading-byte mask for a partial final word (big-endian: MSB is first)
  function automatic logic [31:0] lead_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 32'hFF00_0000;
      3'd2:    return 32'hFFFF_0000;
      3'd3:    return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign mem_wren    = 1'b0;
  assign mem_data_in = '0;
  assign adv         = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lat_q        <= '0;
      rec_addr_q   <= '0;
      rd_addr_q    <= '0;
      remaining_q  <= '0;
      entry_q      <= '0;
      word_q       <= '0;
      word_bytes_q <= '0;
      rec_n_q      <= '0;
      rec_left_q   <= '0;
      csum_q       <= '0;
      mem_address  <= '0;
      out_char     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      rec_addr_q   <= rec_addr_d;
      rd_addr_q    <= rd_addr_d;
      remaining_q  <= remaining_d;
      entry_q      <= entry_d;
      word_q       <= word_d;
      word_bytes_q <= word_bytes_d;
      rec_n_q      <= rec_n_d;
      rec_left_q   <= rec_left_d;
      csum_q       <= csum_d;
      mem_address  <= mem_address_d;
      out_char     <= out_char_d;
      out_valid    <= out_valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next state, record bookkeeping, and the character presented after each transition
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    lat_d         = lat_q;
    rec_addr_d    = rec_addr_q;
    rd_addr_d     = rd_addr_q;
    remaining_d   = remaining_q;
    entry_d       = entry_q;
    word_d        = word_q;
    word_bytes_d  = word_bytes_q;
    rec_n_d       = rec_n_q;
    rec_left_d    = rec_left_q;
    csum_d        = csum_q;
    mem_address_d = mem_address;
    out_char_d    = out_char;
    out_valid_d   = out_valid;
    busy_d        = busy;
    done_d        = done;
    load          = 1'b0;
    wb            = 3'd4;
    cnt_byte      = 8'h00;
    term_sum      = 8'h00;

    case (state_q)
      ADDR:    last_idx = 4'd7;
      DATA:    last_idx = {word_bytes_q, 1'b0} - 4'd1;
      EOL:     last_idx = 4'd0;
      TERM:    last_idx = 4'd14;
      S0:      last_idx = 4'd10;
      default: last_idx = 4'd1;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          rec_addr_d  = base_address & ~32'h3;
          remaining_d = byte_count;
          entry_d     = entry_address;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          idx_d       = '0;
          load        = 1'b1;
`ifdef SREC_DUMP_S0_EN
          state_d     = S0;
`else
          state_d     = (byte_count == '0) ? TERM : HDR;
`endif
        end
      end

      HDR, CNT, ADDR, DATA, CSUM, EOL, TERM, S0: begin
        if (adv) begin
          load = 1'b1;
          if (idx_q != last_idx) begin
            idx_d = idx_q + 4'd1;
          end else begin
            idx_d = '0;
            case (state_q)
              HDR:  state_d = CNT;
              CNT:  state_d = ADDR;
              CSUM: state_d = EOL;
              ADDR: begin
                state_d       = RD;
                lat_d         = '0;
                mem_address_d = rd_addr_q;
              end
              DATA: begin
                if (rec_left_q == '0) begin
                  state_d = CSUM;
                end else begin
                  state_d       = RD;
                  lat_d         = '0;
                  mem_address_d = rd_addr_q;
                end
              end
              EOL: begin
                rec_addr_d  = rec_addr_q + AW'(rec_n_q);
                remaining_d = remaining_q - AW'(rec_n_q);
                state_d     = (remaining_d == '0) ? TERM : HDR;
              end
              TERM: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
              S0:      state_d = (remaining_q == '0) ? TERM : HDR;
              default: state_d = IDLE;
            endcase
          end
        end
      end

      RD: begin
        if (lat_q == LW'(MEM_LATENCY)) begin
          wb           = (rec_left_q < NW'(4)) ? 3'(rec_left_q) : 3'd4;
          word_d       = mem_data_out;
          word_bytes_d = wb;
          rec_left_d   = rec_left_q - NW'(wb);
          csum_d       = csum_q + byte_sum(mem_data_out & lead_mask(wb));
          rd_addr_d    = rd_addr_q + 32'd4;
          state_d      = DATA;
          idx_d        = '0;
          load         = 1'b1;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering a new data record: size it and seed the checksum with count and address
    if (state_d == HDR && state_q != HDR) begin
      rec_n_d    = (remaining_d < AW'(BYTES_PER_REC)) ? NW'(remaining_d) : NW'(BYTES_PER_REC);
      rec_left_d = rec_n_d;
      rd_addr_d  = rec_addr_d;
      csum_d     = 8'(rec_n_d) + 8'd5 + byte_sum(rec_addr_d);
    end

    cnt_byte = 8'(rec_n_d) + 8'd5;
    term_sum = 8'h05 + byte_sum(entry_d);

    if (load) begin
      out_valid_d = 1'b1;
      case (state_d)
        HDR:  out_char_d = idx_d[0] ? CH_3 : CH_S;
        CNT:  out_char_d = hex_c(nib8(cnt_byte, idx_d[0]));
        ADDR: out_char_d = hex_c(nib32(rec_addr_d, idx_d[2:0]));
        DATA: out_char_d = hex_c(nib32(word_d, idx_d[2:0]));
        CSUM: out_char_d = hex_c(nib8(~csum_d, idx_d[0]));
        EOL:  out_char_d = CH_LF;
        TERM: begin
          case (idx_d)
            4'd0:        out_char_d = CH_S;
            4'd1:        out_char_d = CH_7;
            4'd2:        out_char_d = CH_0;
            4'd3:        out_char_d = CH_5;
            4'd12, 4'd13: out_char_d = hex_c(nib8(~term_sum, idx_d[0]));
            4'd14:       out_char_d = CH_LF;
            default:     out_char_d = hex_c(nib32(entry_d, 3'(idx_d - 4'd4)));
          endcase
        end
        S0:   out_char_d = 8'(S0_REC >> (7'd80 - {idx_d, 3'b000}));
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/srec_dumper.md
Name: srec_dumper

Overview:
Reverse of the S-record loader: reads a block of main memory through the mem_controller port and emits it as Motorola S-record ASCII text, one character per handshake. Used by benches and the debug path to dump program or data memory after a run, such as the result region at 0x8002_0000. Output uses S3 data records (32-bit address), followed by one S7 termination record.

Parameters:
BYTES_PER_REC, 16, maximum data bytes per S3 record (legal range 4..32, multiple of 4)
MEM_LATENCY, 1, cycles from mem_address presented to mem_data_out valid

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches base_address, byte_count and entry_address when idle
base_address  input  32  first byte address to dump; low 2 bits forced to 0
byte_count  input  32  number of bytes to dump
entry_address  input  32  address field of the S7 record
mem_address  output  32  word address to mem_controller
mem_wren  output  1  always 0 (read-only master)
mem_data_in  output  32  always 0
mem_data_out  input  32  read data, big-endian (first byte is the most significant byte)
out_char  output  8  ASCII character
out_valid  output  1  out_char is valid
out_ready  input  1  sink accepts out_char when out_valid && out_ready at a rising clock edge
busy  output  1  high from the accepted start until done rises
done  output  1  level; set after the final newline is accepted, cleared by the next start

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0, including mem_address, out_char, out_valid, busy and done. A reset in mid-dump abandons the dump with no partial flush.
- States: IDLE, HDR, CNT, ADDR, RD, DATA, CSUM, EOL, TERM, DONE.
- IDLE:
  - On start, latch the inputs, set busy and clear done.
  - byte_count == 0: go to TERM.
  - Otherwise: go to HDR.
- Record length: n = min(BYTES_PER_REC, remaining bytes).
- HDR: emit 'S','3'.
- CNT: emit the count byte, n+5, as two hex characters.
- ADDR: emit the 4 record-address bytes as 8 hex characters, MSB first.
- RD:
  - Drive mem_address = current word address.
  - Wait MEM_LATENCY cycles, then capture mem_data_out into a word buffer.
  - out_valid is 0 while in RD.
- DATA:
  - Emit buffered bytes MSB first, 2 hex characters per byte.
  - Return to RD at each word boundary while record bytes remain.
  - A partial final word emits only its leading (most significant) bytes.
- CSUM:
  - Emit the one's complement of the low 8 bits of the sum of: count byte, 4 address bytes, all data bytes.
  - The running 8-bit sum wraps mod 256.
- EOL:
  - Emit 0x0A.
  - Record address += n; remaining -= n.
  - remaining > 0: go to HDR. remaining == 0: go to TERM.
- TERM:
  - Emit 'S','7', count "05", entry_address as 8 hex characters, checksum, then 0x0A.
  - Then go to DONE.
- DONE: busy = 0, done = 1; go to IDLE the same cycle.
- Hex digits: uppercase '0'-'9', 'A'-'F'.
- Handshake:
  - out_char and out_valid stay stable until accepted.
  - A new character may be presented in the cycle after acceptance.
  - With out_ready held high, sustained throughput is 1 character per cycle, except for RD bubbles.
- start while busy is ignored.
- Address arithmetic is 32-bit and wraps past 0xFFFF_FFFF without error.

Optional Feature:
SREC_DUMP_S0_EN
- Defined: before the first data record (or before S7 when byte_count == 0), emit the header record "S0030000FC" followed by 0x0A.
- Not defined: no S0 record; output begins with 'S','3'.

Test Plan:
1. base 0x8002_0000, count 4, memory word 0x3C01_1000, entry 0x8002_0000, out_ready=1 -> exact stream "S309800200003C01100027\nS7058002000078\n"; done=1; mem_wren=0 throughout.
2. count 20 from 0x8002_0000 -> two S3 records: count 0x15 at address 80020000, then count 0x09 at address 80020010; every checksum recomputed by the bench matches; 5 distinct word reads.
3. count 6 -> a single record "S30B80020000" with 12 data hex characters (the word at +0 plus the top 2 bytes of the word at +4), then checksum; exactly 2 reads.
4. count 0 -> only "S7058002000078\n"; no memory reads; done asserts.
5. Random out_ready (about 30% duty) on the case 2 dump -> out_char never changes while out_valid=1 and out_ready=0; the stream equals the case 2 stream; a start pulsed mid-dump is ignored.
6. reset_n asserted mid-DATA, then a fresh start with count 4 -> out_valid=0 and busy=0 immediately on reset; the next dump is identical to case 1. With SREC_DUMP_S0_EN defined, case 1 is prefixed by "S0030000FC\n".
